pcie_rx_req_sched: RTL and testbench

- Schedules DMA read requests from two requesters (req0 = command/SQ fetch, req1 = data DMA) onto the PCIe Memory Read (MRd) path.
- Arbitrates between them round-robin and splits each request into MRRS-aligned chunks.
- Allocates a completion tag and a completion-FIFO region per chunk through the rx tag tracker.
- Hands each chunk to the tx request engine. It sits between the DMA engines and the pcie_tx/pcie_rx tag logic.

---
 rtl/pcie_sched_pkg.sv | 26 ++
 rtl/pcie_rr_arb2.sv | 26 ++
 rtl/pcie_rx_req_sched.sv | 160 ++++++++++++++++
 tb/tb_pcie_rx_req_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_sched_pkg.sv
// Shared definitions for the PCIe MRd request scheduler: FSM encoding,
// completion-entry geometry and the MRRS chunk-length helper.
package pcie_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_WAIT  = 3'd2,
      S_ALLOC = 3'd3,
      S_REQ   = 3'd4,
      S_NEXT  = 3'd5
   } sched_state_t;

   localparam int LP_ENTRY_SHIFT   = 6;
   localparam int LP_TAG_LOW_WIDTH = 4;

   // Largest chunk that neither exceeds the remaining length nor crosses an MRRS boundary.
   function automatic logic [6:0] chunk_len(input logic [6:0] rem,
                                            input logic [6:0] addr_lo,
                                            input logic [6:0] mrrs_units);
      logic [6:0] room;
      room      = mrrs_units - addr_lo;
      chunk_len = (rem < room) ? rem : room;
   endfunction

endpackage

// File: rtl/pcie_rr_arb2.sv
// Two-input round-robin arbiter; priority moves to the other requester only
// when i_upd strobes at the end of a whole request.
module pcie_rr_arb2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_upd,
   input  logic i_served,
   output logic o_gnt,
   output logic o_gnt_vld
);

   logic r_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   r_ptr <= 1'b0;
      else if (i_upd) r_ptr <= ~i_served;
   end

   always_comb begin
      o_gnt_vld = i_req0 | i_req1;
      o_gnt     = (i_req0 & i_req1) ? r_ptr : i_req1;
   end

endmodule

// File: rtl/pcie_rx_req_sched.sv
// Schedules two DMA read requesters onto the MRd path in MRRS-aligned chunks,
// allocating a tag and completion-FIFO space per chunk. Optional counters: PCIE_RX_REQ_SCHED_STAT_EN.
module pcie_rx_req_sched
   import pcie_sched_pkg::*;
#(
   parameter int         C_PCIE_ADDR_WIDTH  = 36,
   parameter int         P_FIFO_DEPTH_WIDTH = 9,
   parameter int         P_MRRS_SHIFT       = 9,
   parameter logic [3:0] P_TAG_PREFIX       = 4'b0001
) (
   input  logic                              pcie_user_clk,
   input  logic                              pcie_user_rst_n,
   input  logic                              req0_valid,
   input  logic [C_PCIE_ADDR_WIDTH-7:0]      req0_addr,
   input  logic [6:0]                        req0_len,
   output logic                              req0_done,
   input  logic                              req1_valid,
   input  logic [C_PCIE_ADDR_WIDTH-7:0]      req1_addr,
   input  logic [6:0]                        req1_len,
   output logic                              req1_done,
   output logic                              pcie_tag_alloc,
   output logic [7:0]                        pcie_alloc_tag,
   output logic [4:0]                        pcie_tag_alloc_len,
   input  logic                              pcie_tag_full_n,
   input  logic [P_FIFO_DEPTH_WIDTH:0]       rear_full_addr,
   input  logic [P_FIFO_DEPTH_WIDTH:0]       fifo_front_addr,
   output logic                              tx_mrd_req,
   output logic [7:0]                        tx_mrd_tag,
   output logic [C_PCIE_ADDR_WIDTH-3:0]      tx_mrd_addr,
   output logic [4:0]                        tx_mrd_len,
   input  logic                              tx_mrd_ack
`ifdef PCIE_RX_REQ_SCHED_STAT_EN
   ,
   output logic [31:0]                       stat_mrd_cnt,
   output logic [31:0]                       stat_stall_cnt
`endif
);

   localparam int         LP_AW         = C_PCIE_ADDR_WIDTH - LP_ENTRY_SHIFT;
   localparam int         LP_FW         = P_FIFO_DEPTH_WIDTH + 1;
   localparam logic [6:0] LP_MRRS_UNITS = 7'(1 << (P_MRRS_SHIFT - LP_ENTRY_SHIFT));

   sched_state_t                r_state, w_next;
   logic                        r_gnt;
   logic [LP_AW-1:0]            r_addr;
   logic [6:0]                  r_rem;
   logic [4:0]                  r_chunk;
   logic [LP_TAG_LOW_WIDTH-1:0] r_tag_cnt;
   logic [LP_TAG_LOW_WIDTH-1:0] r_cur_tag;

   logic                        w_gnt, w_gnt_vld, w_last, w_proceed;
   logic [LP_FW-1:0]            w_used;

   pcie_rr_arb2 u_arb (
      .i_clk     (pcie_user_clk),
      .i_rst_n   (pcie_user_rst_n),
      .i_req0    (req0_valid),
      .i_req1    (req1_valid),
      .i_upd     (w_last),
      .i_served  (r_gnt),
      .o_gnt     (w_gnt),
      .o_gnt_vld (w_gnt_vld)
   );

   // FIFO occupancy is modular; one extra bit in the compare lets "exactly full" pass.
   assign w_used    = rear_full_addr - fifo_front_addr;
   assign w_proceed = pcie_tag_full_n &&
                      (({1'b0, w_used} + (LP_FW+1)'(r_chunk)) <= (LP_FW+1)'(1 << P_FIFO_DEPTH_WIDTH));
   assign w_last    = (r_state == S_NEXT) && (r_rem == 7'd0);

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) r_state <= S_IDLE;
      else                  r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt_vld) w_next = S_CALC;
         S_CALC:  w_next = S_WAIT;
         S_WAIT:  if (w_proceed) w_next = S_ALLOC;
         S_ALLOC: w_next = S_REQ;
         S_REQ:   if (tx_mrd_ack) w_next = S_NEXT;
         S_NEXT:  w_next = (r_rem != 7'd0) ? S_CALC : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      pcie_tag_alloc     = 1'b0;
      pcie_alloc_tag     = 8'd0;
      pcie_tag_alloc_len = 5'd0;
      tx_mrd_req         = 1'b0;
      tx_mrd_tag         = 8'd0;
      tx_mrd_addr        = '0;
      tx_mrd_len         = 5'd0;
      req0_done          = w_last && !r_gnt;
      req1_done          = w_last &&  r_gnt;
      if (r_state == S_ALLOC) begin
         pcie_tag_alloc     = 1'b1;
         pcie_alloc_tag     = {P_TAG_PREFIX, r_tag_cnt};
         pcie_tag_alloc_len = r_chunk;
      end
      if (r_state == S_REQ) begin
         tx_mrd_req  = 1'b1;
         tx_mrd_tag  = {P_TAG_PREFIX, r_cur_tag};
         tx_mrd_addr = {r_addr, 4'b0000};
         tx_mrd_len  = r_chunk;
      end
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         r_gnt     <= 1'b0;
         r_addr    <= '0;
         r_rem     <= 7'd0;
         r_chunk   <= 5'd0;
         r_tag_cnt <= '0;
         r_cur_tag <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_gnt_vld) begin
               r_gnt  <= w_gnt;
               r_addr <= w_gnt ? req1_addr : req0_addr;
               r_rem  <= ((w_gnt ? req1_len : req0_len) == 7'd0) ? 7'd64 : (w_gnt ? req1_len : req0_len);
            end
            S_CALC:  r_chunk <= 5'(chunk_len(r_rem, r_addr[6:0] & (LP_MRRS_UNITS - 7'd1), LP_MRRS_UNITS));
            S_ALLOC: begin
               r_cur_tag <= r_tag_cnt;
               r_tag_cnt <= r_tag_cnt + 1'b1;
            end
            S_REQ: if (tx_mrd_ack) begin
               r_addr <= r_addr + LP_AW'(r_chunk);
               r_rem  <= r_rem - 7'(r_chunk);
            end
            default: ;
         endcase
      end
   end

`ifdef PCIE_RX_REQ_SCHED_STAT_EN
   logic [31:0] r_stat_mrd, r_stat_stall;

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         r_stat_mrd   <= 32'd0;
         r_stat_stall <= 32'd0;
      end else begin
         if ((r_state == S_REQ) && tx_mrd_ack && (r_stat_mrd != '1))
            r_stat_mrd <= r_stat_mrd + 32'd1;
         if ((r_state == S_WAIT) && !w_proceed && (r_stat_stall != '1))
            r_stat_stall <= r_stat_stall + 32'd1;
      end
   end

   assign stat_mrd_cnt   = r_stat_mrd;
   assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_pcie_rx_req_sched.sv
// Scoreboard bench for pcie_rx_req_sched: expected MRd chunks and done pulses
// are queued when requests are presented and popped as the DUT produces them.
module tb_pcie_rx_req_sched;

   typedef struct {
      logic [7:0]  tag;
      logic [33:0] addr;
      logic [4:0]  len;
   } mrd_t;

   typedef struct {
      logic [29:0] addr;
      logic [6:0]  len;
   } rq_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_done, req1_done;
   logic [29:0] req0_addr, req1_addr;
   logic [6:0]  req0_len, req1_len;
   logic        pcie_tag_alloc, pcie_tag_full_n;
   logic [7:0]  pcie_alloc_tag, tx_mrd_tag;
   logic [4:0]  pcie_tag_alloc_len, tx_mrd_len;
   logic [9:0]  rear_full_addr, fifo_front_addr;
   logic        tx_mrd_req, tx_mrd_ack;
   logic [33:0] tx_mrd_addr;
`ifdef PCIE_RX_REQ_SCHED_STAT_EN
   logic [31:0] stat_mrd_cnt, stat_stall_cnt;
`endif

   pcie_rx_req_sched dut (
      .pcie_user_clk      (clk),
      .pcie_user_rst_n    (rst_n),
      .req0_valid         (req0_valid),
      .req0_addr          (req0_addr),
      .req0_len           (req0_len),
      .req0_done          (req0_done),
      .req1_valid         (req1_valid),
      .req1_addr          (req1_addr),
      .req1_len           (req1_len),
      .req1_done          (req1_done),
      .pcie_tag_alloc     (pcie_tag_alloc),
      .pcie_alloc_tag     (pcie_alloc_tag),
      .pcie_tag_alloc_len (pcie_tag_alloc_len),
      .pcie_tag_full_n    (pcie_tag_full_n),
      .rear_full_addr     (rear_full_addr),
      .fifo_front_addr    (fifo_front_addr),
      .tx_mrd_req         (tx_mrd_req),
      .tx_mrd_tag         (tx_mrd_tag),
      .tx_mrd_addr        (tx_mrd_addr),
      .tx_mrd_len         (tx_mrd_len),
      .tx_mrd_ack         (tx_mrd_ack)
`ifdef PCIE_RX_REQ_SCHED_STAT_EN
      ,
      .stat_mrd_cnt       (stat_mrd_cnt),
      .stat_stall_cnt     (stat_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   mrd_t       exp_q[$];
   int         done_q[$];
   rq_t        pend0[$], pend1[$];
   int         checks = 0, errors = 0;
   int         ack_delay = 0, wait_cnt = 0, alloc_seen = 0, hs_cnt = 0;
   bit         ack_en = 1'b1, prev_alloc = 1'b0, prev_req = 1'b0, prev_hs = 1'b0;
   logic [3:0] m_tag = 4'd0;

   // Requesters hold valid and operands until their done pulse is seen.
   task automatic drive_req();
      req0_valid = (pend0.size() != 0);
      req0_addr  = req0_valid ? pend0[0].addr : 30'd0;
      req0_len   = req0_valid ? pend0[0].len  : 7'd0;
      req1_valid = (pend1.size() != 0);
      req1_addr  = req1_valid ? pend1[0].addr : 30'd0;
      req1_len   = req1_valid ? pend1[0].len  : 7'd0;
   endtask

   // Reference split: 512 B MRRS = 8 entries, never crossing an 8-entry boundary.
   task automatic push_req(input int id, input logic [29:0] addr, input logic [6:0] len);
      int          rem, room, c;
      logic [29:0] a;
      mrd_t        m;
      rq_t         r;
      r.addr = addr;
      r.len  = len;
      if (id == 0) pend0.push_back(r);
      else         pend1.push_back(r);
      rem = (len == 7'd0) ? 64 : int'(len);
      a   = addr;
      while (rem > 0) begin
         room   = 8 - int'(a[2:0]);
         c      = (rem < room) ? rem : room;
         m.tag  = {4'h1, m_tag};
         m.addr = {a, 4'b0000};
         m.len  = 5'(c);
         exp_q.push_back(m);
         m_tag  = m_tag + 4'd1;
         a      = a + 30'(c);
         rem    = rem - c;
      end
      done_q.push_back(id);
   endtask

   task automatic step();
      bit hs;
      int id;
      @(posedge clk); #1;
      hs = 1'b0;
      if (prev_hs) begin
         checks++;
         if (tx_mrd_req !== 1'b0) begin
            errors++; $display("FAIL req_drop got=%b exp=0", tx_mrd_req);
         end
      end
      if (pcie_tag_alloc) begin
         alloc_seen++; checks++;
         if (prev_alloc) begin
            errors++; $display("FAIL alloc_pulse got=two-cycle exp=one-cycle");
         end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL alloc_unexpected got tag=%h exp=none", pcie_alloc_tag);
         end else if (pcie_alloc_tag !== exp_q[0].tag || pcie_tag_alloc_len !== exp_q[0].len) begin
            errors++; $display("FAIL alloc got tag=%h len=%0d exp tag=%h len=%0d",
                               pcie_alloc_tag, pcie_tag_alloc_len, exp_q[0].tag, exp_q[0].len);
         end
      end
      if (tx_mrd_req) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL mrd_unexpected got tag=%h exp=none", tx_mrd_tag);
         end else if (!prev_req && !prev_alloc) begin
            errors++; $display("FAIL alloc_order got alloc_prev=0 exp=1 tag=%h", tx_mrd_tag);
         end else if (tx_mrd_tag !== exp_q[0].tag || tx_mrd_addr !== exp_q[0].addr ||
                      tx_mrd_len !== exp_q[0].len) begin
            errors++; $display("FAIL mrd got tag=%h addr=%h len=%0d exp tag=%h addr=%h len=%0d",
                               tx_mrd_tag, tx_mrd_addr, tx_mrd_len,
                               exp_q[0].tag, exp_q[0].addr, exp_q[0].len);
         end
         if (ack_en && wait_cnt >= ack_delay) begin
            hs = 1'b1; wait_cnt = 0; hs_cnt++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end else begin
            wait_cnt++;
         end
      end
      tx_mrd_ack = hs;
      if (req0_done || req1_done) begin
         checks++;
         id = req1_done ? 1 : 0;
         if (req0_done && req1_done) begin
            errors++; $display("FAIL done_both got=11 exp=one-hot");
         end else if (done_q.size() == 0 || done_q[0] != id) begin
            errors++; $display("FAIL done_order got=%0d exp=%0d", id,
                               (done_q.size() != 0) ? done_q[0] : -1);
         end else if (exp_q.size() != 0 && prev_hs == 1'b0) begin
            errors++; $display("FAIL done_early got=done exp=after-last-ack");
         end
         if (done_q.size() != 0) void'(done_q.pop_front());
         if (id == 0 && pend0.size() != 0) void'(pend0.pop_front());
         if (id == 1 && pend1.size() != 0) void'(pend1.pop_front());
      end
      prev_alloc = pcie_tag_alloc;
      prev_req   = tx_mrd_req;
      prev_hs    = hs;
      drive_req();
   endtask

   task automatic run_until_empty(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
         step(); n++;
      end
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         errors++; $display("FAIL timeout got pending=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
      end
      step(); step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tx_mrd_ack = 1'b0; pcie_tag_full_n = 1'b1;
      rear_full_addr = 10'd0; fifo_front_addr = 10'd0;
      drive_req();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx_mrd_req !== 1'b0 || pcie_tag_alloc !== 1'b0) begin
         errors++; $display("FAIL rst_strobes got req=%b alloc=%b exp=0/0", tx_mrd_req, pcie_tag_alloc);
      end
      checks++;
      if (pcie_alloc_tag !== 8'd0 || tx_mrd_tag !== 8'd0 || tx_mrd_addr !== 34'd0) begin
         errors++; $display("FAIL rst_fields got atag=%h ttag=%h addr=%h exp=0", pcie_alloc_tag, tx_mrd_tag, tx_mrd_addr);
      end
      checks++;
      if (req0_done !== 1'b0 || req1_done !== 1'b0 || tx_mrd_len !== 5'd0 || pcie_tag_alloc_len !== 5'd0) begin
         errors++; $display("FAIL rst_done got d0=%b d1=%b exp=0/0", req0_done, req1_done);
      end
      rst_n = 1'b1;
      repeat (3) step();
      checks++;
      if (tx_mrd_req !== 1'b0) begin
         errors++; $display("FAIL idle_req got=%b exp=0", tx_mrd_req);
      end
   endtask

   task automatic test_aligned();
      ack_delay = 0;
      push_req(0, 30'h40, 7'd16);
      drive_req();
      run_until_empty(200);
   endtask

   task automatic test_unaligned();
      ack_delay = 2;
      push_req(1, 30'h45, 7'd10);
      drive_req();
      run_until_empty(200);
   endtask

   task automatic test_round_robin();
      ack_delay = 1;
      push_req(0, 30'h100, 7'd8);
      push_req(1, 30'h203, 7'd20);
      push_req(0, 30'h300, 7'd0);
      push_req(1, 30'h007, 7'd1);
      push_req(0, 30'h041, 7'd7);
      drive_req();
      run_until_empty(2000);
   endtask

   task automatic test_backpressure();
      int alloc0;
`ifdef PCIE_RX_REQ_SCHED_STAT_EN
      logic [31:0] stall0;
      stall0 = stat_stall_cnt;
`endif
      ack_delay = 0;
      pcie_tag_full_n = 1'b0;
      rear_full_addr  = 10'd5;
      fifo_front_addr = 10'd519;
      alloc0 = alloc_seen;
      push_req(0, 30'h0, 7'd8);
      drive_req();
      for (int i = 0; i < 20; i++) step();
      pcie_tag_full_n = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         step();
         fifo_front_addr = 10'(519 + f);
      end
      checks++;
      if (alloc_seen != alloc0) begin
         errors++; $display("FAIL stall_alloc got=%0d exp=0", alloc_seen - alloc0);
      end
      run_until_empty(100);
      checks++;
      if (alloc_seen != alloc0 + 1) begin
         errors++; $display("FAIL stall_release got=%0d exp=1", alloc_seen - alloc0);
      end
`ifdef PCIE_RX_REQ_SCHED_STAT_EN
      checks++;
      if (stat_stall_cnt - stall0 !== 32'd24) begin
         errors++; $display("FAIL stat_stall got=%0d exp=24", stat_stall_cnt - stall0);
      end
      checks++;
      if (stat_mrd_cnt !== 32'(hs_cnt)) begin
         errors++; $display("FAIL stat_mrd got=%0d exp=%0d", stat_mrd_cnt, hs_cnt);
      end
`endif
      rear_full_addr  = 10'd0;
      fifo_front_addr = 10'd0;
   endtask

   task automatic test_tag_wrap();
      ack_delay = 0;
      push_req(1, 30'h3FFF_FFFC, 7'd8);
      push_req(0, 30'h0, 7'd0);
      push_req(0, 30'h40, 7'd0);
      drive_req();
      run_until_empty(3000);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      ack_en = 1'b0;
      push_req(0, 30'h80, 7'd16);
      drive_req();
      while (!tx_mrd_req && n < 30) begin step(); n++; end
      checks++;
      if (tx_mrd_req !== 1'b1) begin
         errors++; $display("FAIL reach_req got=%b exp=1", tx_mrd_req);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx_mrd_req !== 1'b0 || pcie_tag_alloc !== 1'b0) begin
         errors++; $display("FAIL mid_rst got req=%b alloc=%b exp=0/0", tx_mrd_req, pcie_tag_alloc);
      end
      exp_q.delete(); done_q.delete(); pend0.delete(); pend1.delete();
      m_tag = 4'd0; hs_cnt = 0; wait_cnt = 0;
      tx_mrd_ack = 1'b0;
      drive_req();
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (req0_done !== 1'b0 || req1_done !== 1'b0) begin
            errors++; $display("FAIL rst_done got=%b%b exp=00", req0_done, req1_done);
         end
      end
      rst_n = 1'b1;
      prev_alloc = 1'b0; prev_req = 1'b0; prev_hs = 1'b0;
      ack_en = 1'b1; ack_delay = 0;
      push_req(1, 30'h10, 7'd4);
      drive_req();
      run_until_empty(200);
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_unaligned();
      test_round_robin();
      test_backpressure();
      test_tag_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
